// File: rtl/neurosa_pkg.sv
// Shared types and command codes for the neuron array sequencer.
package neurosa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN_CNT,
        RUN,
        READ
    } state_e;

    typedef enum logic [1:0] {
        F_VMEM    = 2'd0,
        F_MU      = 2'd1,
        F_NEURONI = 2'd2,
        F_Q       = 2'd3
    } field_e;

    localparam logic [15:0] CMD_LOAD = 16'hFFFF;
    localparam logic [15:0] CMD_RUN  = 16'hFFFE;
    localparam logic [15:0] CMD_READ = 16'hFFFD;
    localparam logic [15:0] CMD_CLR  = 16'hFFFC;

    // Smallest b >= 1 such that 2^b >= n.
    function automatic logic [3:0] calc_bits(input int unsigned n);
        logic [3:0] b;
        b = 4'd15;
        for (int i = 15; i >= 1; i--) begin
            if ((32'd1 << i) >= n) b = 4'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/probe_readout_ser.sv
// Serialises the probe vector into OUT_W-bit words with valid/ready/last.
// Bits at or above active_n read as zero.
module probe_readout_ser #(
    parameter int NUM_N = 256,
    parameter int ID_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_N-1:0] probes,
    input  logic [ID_W:0]    active_n,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done
);
    localparam int AN_W    = ID_W + 1;
    localparam int N_WORDS = (NUM_N + OUT_W - 1) / OUT_W;
    localparam int PAD_N   = N_WORDS * OUT_W;
    localparam int SH_W    = $clog2(PAD_N) + 1;

    logic [AN_W-1:0]  word_reg;
    logic [AN_W-1:0]  sel;
    logic [AN_W-1:0]  last_idx;
    logic [AN_W:0]    word_cnt;
    logic [PAD_N-1:0] masked;
    logic [PAD_N-1:0] shifted;
    logic [SH_W-1:0]  shift_amt;
    logic [OUT_W-1:0] word_bits;
    logic             advance;

    assign advance = out_valid & out_ready;
    assign done    = advance & out_last;

    // Select the word to load next: word 0 on start, otherwise the following word.
    always_comb begin
        word_cnt  = ({1'b0, active_n} + (AN_W+1)'(OUT_W - 1)) / (AN_W+1)'(OUT_W);
        last_idx  = AN_W'(word_cnt - (AN_W+1)'(1));
        sel       = start ? '0 : word_reg + AN_W'(1);
        masked    = PAD_N'(probes) & ~({PAD_N{1'b1}} << active_n);
        shift_amt = SH_W'(sel) * SH_W'(OUT_W);
        shifted   = masked >> shift_amt;
        word_bits = shifted[OUT_W-1:0];
    end

    // Output word register; data and last only change on start or a completed handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (start) begin
            word_reg  <= '0;
            out_data  <= word_bits;
            out_valid <= 1'b1;
            out_last  <= (last_idx == AN_W'(0));
        end else if (advance) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                word_reg <= sel;
                out_data <= word_bits;
                out_last <= (sel == last_idx);
            end
        end
    end

endmodule

// File: rtl/neuron_array_seq.sv
// Command-driven sequencer: loads neuron fields, runs the network for a
// programmed iteration count, collects spike probes and streams them out.
module neuron_array_seq
    import neurosa_pkg::*;
#(
    parameter int FP_W  = 16,
    parameter int TEN_W = 2,
    parameter int NUM_N = 256,
    parameter int ID_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [1:0]       wr_field,
    output logic [ID_W-1:0]  wr_idx,
    output logic [FP_W-1:0]  wr_data,
    output logic             en_array,
    input  logic             net_done,
    input  logic [ID_W-1:0]  spike_id,
    input  logic [TEN_W-1:0] spike_ten,
    output logic [ID_W:0]    active_n,
    output logic [3:0]       active_bits,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);
    localparam int AN_W = ID_W + 1;
    localparam logic [FP_W-1:0] NUM_N_FP = FP_W'(NUM_N);

    state_e           state_reg, state_next;
    logic [AN_W-1:0]  active_n_reg;
    logic [3:0]       active_bits_reg;
    logic [FP_W-1:0]  cnt_reg;
    logic [ID_W-1:0]  load_idx_reg;
    logic [1:0]       load_field_reg;
    logic             wr_en_reg;
    logic [1:0]       wr_field_reg;
    logic [ID_W-1:0]  wr_idx_reg;
    logic [FP_W-1:0]  wr_data_reg;
    logic             read_started_reg;
    logic [NUM_N-1:0] probes_reg;

    logic set_active, clr_probes, load_accept, iter_accept, run_step;
    logic read_go, ser_start, ser_done, spike_hit;

    assign read_go   = (state_reg == READ) && !read_started_reg;
    assign spike_hit = run_step && (spike_ten != '0) && (AN_W'(spike_id) < active_n_reg);

    assign en_array    = (state_reg == RUN);
    assign busy        = (state_reg != IDLE);
    assign active_n    = active_n_reg;
    assign active_bits = active_bits_reg;
    assign wr_en       = wr_en_reg;
    assign wr_field    = wr_field_reg;
    assign wr_idx      = wr_idx_reg;
    assign wr_data     = wr_data_reg;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state decode, input handshake and per-state action strobes.
    always_comb begin
        state_next  = state_reg;
        in_ready    = 1'b0;
        set_active  = 1'b0;
        clr_probes  = 1'b0;
        load_accept = 1'b0;
        iter_accept = 1'b0;
        run_step    = 1'b0;
        ser_start   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == FP_W'(CMD_LOAD))      state_next = LOAD;
                    else if (in_data == FP_W'(CMD_RUN))  state_next = RUN_CNT;
                    else if (in_data == FP_W'(CMD_READ)) state_next = READ;
                    else if (in_data == FP_W'(CMD_CLR))  clr_probes = 1'b1;
                    else                                 set_active = 1'b1;
                end
            end
            LOAD: begin
                if (active_n_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load_accept = 1'b1;
                        if (load_field_reg == F_Q &&
                            AN_W'(load_idx_reg) == active_n_reg - AN_W'(1))
                            state_next = IDLE;
                    end
                end
            end
            RUN_CNT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == '0) begin
                        state_next = IDLE;
                    end else begin
                        iter_accept = 1'b1;
                        state_next  = RUN;
                    end
                end
            end
            RUN: begin
                if (net_done) begin
                    run_step = 1'b1;
                    if (cnt_reg <= FP_W'(1)) state_next = IDLE;
                end
            end
            READ: begin
                if (read_go) begin
                    if (active_n_reg == '0) state_next = IDLE;
                    else                    ser_start  = 1'b1;
                end else if (ser_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Configuration, load addressing, write strobe and iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_n_reg     <= AN_W'(NUM_N);
            active_bits_reg  <= 4'($clog2(NUM_N));
            cnt_reg          <= '0;
            load_idx_reg     <= '0;
            load_field_reg   <= '0;
            wr_en_reg        <= 1'b0;
            wr_field_reg     <= '0;
            wr_idx_reg       <= '0;
            wr_data_reg      <= '0;
            read_started_reg <= 1'b0;
        end else begin
            active_bits_reg  <= calc_bits(32'(active_n_reg));
            wr_en_reg        <= 1'b0;
            read_started_reg <= (state_reg == READ);
            if (set_active)
                active_n_reg <= (in_data <= NUM_N_FP) ? AN_W'(in_data) : AN_W'(NUM_N);
            if (state_reg == IDLE) begin
                load_idx_reg   <= '0;
                load_field_reg <= '0;
            end
            if (load_accept) begin
                wr_en_reg      <= 1'b1;
                wr_idx_reg     <= load_idx_reg;
                wr_field_reg   <= load_field_reg;
                wr_data_reg    <= in_data;
                load_field_reg <= load_field_reg + 2'd1;
                if (load_field_reg == F_Q) load_idx_reg <= load_idx_reg + ID_W'(1);
            end
            if (iter_accept)
                cnt_reg <= in_data;
            else if (run_step && cnt_reg != '0)
                cnt_reg <= cnt_reg - FP_W'(1);
        end
    end

    // One probe bit per neuron: set on reset/clear, toggled by a qualifying spike.
    for (genvar gi = 0; gi < NUM_N; gi++) begin : g_probe
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                probes_reg[gi] <= 1'b1;
            else if (clr_probes)
                probes_reg[gi] <= 1'b1;
            else if (spike_hit && spike_id == ID_W'(gi))
                probes_reg[gi] <= ~probes_reg[gi];
        end
    end

    probe_readout_ser #(
        .NUM_N (NUM_N),
        .ID_W  (ID_W),
        .OUT_W (OUT_W)
    ) u_readout (
        .clk       (clk),
        .rst       (reset),
        .start     (ser_start),
        .probes    (probes_reg),
        .active_n  (active_n_reg),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_neuron_array_seq.sv
// Bench for neuron_array_seq: table of active_n programming vectors plus
// hand-written load/run/read/reset sequences, checked through scoreboards.
module tb_neuron_array_seq;
    localparam int FP_W  = 16;
    localparam int TEN_W = 2;
    localparam int NUM_N = 256;
    localparam int ID_W  = 8;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [FP_W-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             wr_en;
    logic [1:0]       wr_field;
    logic [ID_W-1:0]  wr_idx;
    logic [FP_W-1:0]  wr_data;
    logic             en_array;
    logic             net_done = 1'b0;
    logic [ID_W-1:0]  spike_id = '0;
    logic [TEN_W-1:0] spike_ten = '0;
    logic [ID_W:0]    active_n;
    logic [3:0]       active_bits;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last;
    logic             busy;

    typedef struct {
        logic [ID_W-1:0] idx;
        logic [1:0]      field;
        logic [FP_W-1:0] data;
    } wr_exp_t;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } rd_exp_t;

    typedef struct {
        logic [15:0]   value;
        logic [ID_W:0] exp_n;
        logic [3:0]    exp_bits;
    } an_vec_t;

    wr_exp_t          wr_q[$];
    rd_exp_t          rd_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [NUM_N-1:0] model_probes = '1;
    int               model_n = NUM_N;
    int               stall_left = 0;
    logic [OUT_W-1:0] held_data = '0;
    logic             held_last = 1'b0;
    logic             held_valid = 1'b0;
    an_vec_t          vecs[12];

    neuron_array_seq #(
        .FP_W(FP_W), .TEN_W(TEN_W), .NUM_N(NUM_N), .ID_W(ID_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_field(wr_field), .wr_idx(wr_idx), .wr_data(wr_data),
        .en_array(en_array), .net_done(net_done), .spike_id(spike_id), .spike_ten(spike_ten),
        .active_n(active_n), .active_bits(active_bits), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write and readout monitor; also drives out_ready from the stall budget.
    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wr_en", 32'(wr_en), 32'd0);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                $display("wr idx=%0d field=%0d data=0x%04h", wr_idx, wr_field, wr_data);
                check("wr_idx", 32'(wr_idx), 32'(e.idx));
                check("wr_field", 32'(wr_field), 32'(e.field));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
        if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
        if (out_valid && !out_ready) begin
            if (held_valid) begin
                check("hold_data", 32'(out_data), 32'(held_data));
                check("hold_last", 32'(out_last), 32'(held_last));
            end
            held_valid = 1'b1;
            held_data  = out_data;
            held_last  = out_last;
        end else if (out_valid) begin
            if (held_valid) check("hold_release_data", 32'(out_data), 32'(held_data));
            held_valid = 1'b0;
            if (rd_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                $display("rd data=0x%04h last=%0d", out_data, out_last);
                check("rd_data", 32'(out_data), 32'(e.data));
                check("rd_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic send_word(input logic [15:0] w);
        int t = 0;
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic program_n(input logic [15:0] v);
        send_word(v);
        model_n = (int'(v) <= NUM_N) ? int'(v) : NUM_N;
    endtask

    task automatic expect_read();
        int w = (model_n + OUT_W - 1) / OUT_W;
        for (int k = 0; k < w; k++) begin
            rd_exp_t e;
            e.data = '0;
            for (int j = 0; j < OUT_W; j++) begin
                int b = k * OUT_W + j;
                if (b < model_n) e.data[j] = model_probes[b];
            end
            e.last = (k == w - 1);
            rd_q.push_back(e);
        end
    endtask

    task automatic do_read(input int stall);
        int t = 0;
        stall_left = stall;
        expect_read();
        send_word(16'hFFFD);
        while ((rd_q.size() != 0 || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("read_done_in_time", 32'(t < 400), 32'd1);
        check("read_queue_empty", 32'(rd_q.size()), 32'd0);
    endtask

    task automatic spike(input int id, input int ten);
        @(negedge clk);
        check("en_array_in_run", 32'(en_array), 32'd1);
        net_done  = 1'b1;
        spike_id  = ID_W'(id);
        spike_ten = TEN_W'(ten);
        if (ten != 0 && id < model_n) model_probes[id] = ~model_probes[id];
        @(negedge clk);
        net_done  = 1'b0;
        spike_ten = '0;
    endtask

    initial begin
        vecs[0]  = '{16'h0003,   9'd3, 4'd2};
        vecs[1]  = '{16'h0005,   9'd5, 4'd3};
        vecs[2]  = '{16'h0014,  9'd20, 4'd5};
        vecs[3]  = '{16'h0200, 9'd256, 4'd8};
        vecs[4]  = '{16'h0001,   9'd1, 4'd1};
        vecs[5]  = '{16'h0002,   9'd2, 4'd1};
        vecs[6]  = '{16'h0100, 9'd256, 4'd8};
        vecs[7]  = '{16'h0000,   9'd0, 4'd1};
        vecs[8]  = '{16'h0011,  9'd17, 4'd5};
        vecs[9]  = '{16'h0101, 9'd256, 4'd8};
        vecs[10] = '{16'h0004,   9'd4, 4'd2};
        vecs[11] = '{16'h0009,   9'd9, 4'd4};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en_array", 32'(en_array), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_active_n", 32'(active_n), 32'd256);
        check("rst_active_bits", 32'(active_bits), 32'd8);
        reset = 1'b0;

        // Table: active_n programming, clamping and active_bits
        for (int i = 0; i < 12; i++) begin
            program_n(vecs[i].value);
            check("vec_active_n", 32'(active_n), 32'(vecs[i].exp_n));
            @(negedge clk);
            $display("vec %0d value=0x%04h active_n=%0d active_bits=%0d",
                     i, vecs[i].value, active_n, active_bits);
            check("vec_active_bits", 32'(active_bits), 32'(vecs[i].exp_bits));
            check("vec_busy", 32'(busy), 32'd0);
        end

        // Load 3 neurons x 4 fields
        program_n(16'h0003);
        send_word(16'hFFFF);
        check("load_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 12; i++) begin
            wr_exp_t e;
            e.idx   = ID_W'(i / 4);
            e.field = 2'(i % 4);
            e.data  = 16'hA000 + 16'(i);
            wr_q.push_back(e);
            send_word(e.data);
        end
        @(negedge clk);
        check("load_end_busy", 32'(busy), 32'd0);
        check("load_queue_empty", 32'(wr_q.size()), 32'd0);

        // Run 3 iterations with mixed spikes; stray net_done in IDLE is ignored
        program_n(16'h0005);
        @(negedge clk);
        net_done = 1'b1; spike_id = 8'd0; spike_ten = 2'd1;
        @(negedge clk);
        net_done = 1'b0; spike_ten = '0;
        send_word(16'hFFFE);
        send_word(16'h0003);
        spike(1, 1);
        spike(7, 2);
        spike(2, 0);
        check("run_end_en_array", 32'(en_array), 32'd0);
        check("run_end_busy", 32'(busy), 32'd0);
        do_read(0);

        // Clear, 20 neurons, stalled readout
        send_word(16'hFFFC);
        model_probes = '1;
        program_n(16'h0014);
        do_read(5);

        // active_n == 0: no writes, no words
        program_n(16'h0000);
        send_word(16'hFFFF);
        @(negedge clk);
        check("zero_load_busy", 32'(busy), 32'd0);
        send_word(16'hFFFD);
        for (int i = 0; i < 3; i++) begin
            check("zero_read_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        check("zero_read_busy", 32'(busy), 32'd0);

        // Clamp and ITER == 0
        program_n(16'h0200);
        check("clamp_active_n", 32'(active_n), 32'd256);
        @(negedge clk);
        check("clamp_active_bits", 32'(active_bits), 32'd8);
        send_word(16'hFFFE);
        send_word(16'h0000);
        for (int i = 0; i < 3; i++) begin
            check("iter0_en_array", 32'(en_array), 32'd0);
            @(negedge clk);
        end
        check("iter0_busy", 32'(busy), 32'd0);

        // Reset in the middle of a 5-iteration run
        program_n(16'h0010);
        send_word(16'hFFFE);
        send_word(16'h0001);
        spike(3, 1);
        check("pre_busy", 32'(busy), 32'd0);
        send_word(16'hFFFE);
        send_word(16'h0005);
        check("mid_run_en_array", 32'(en_array), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_en_array", 32'(en_array), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_active_n", 32'(active_n), 32'd256);
        check("async_rst_active_bits", 32'(active_bits), 32'd8);
        @(negedge clk);
        reset = 1'b0;
        model_n = NUM_N;
        model_probes = '1;
        do_read(0);

        check("final_wr_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
